key_count_display: RTL and testbench

- Downstream consumer of the key-debounce/scan-clock stage.
- Counts debounced key-press pulses (anjian_en) in a DIG_N-digit decimal BCD counter.
- Drives a multiplexed 7-segment display: one digit at a time, advancing on each rising edge of the slow scan signal wei_clk.
- Single clock domain; wei_clk is treated as a data signal, never as a clock.

---
 rtl/seg_pkg.sv | 8 +
 rtl/seg7_decode.sv | 11 +
 rtl/key_count_display.sv | 82 ++++++++
 tb/tb_key_count_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment constants, active-high patterns {dp,g,f,e,d,c,b,a}.
package seg_pkg;
    localparam int BCD_W = 4;
    localparam int DIG_N_DEF = 4;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [9:0][7:0] SEG_PAT = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
                                           8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to 7-segment pattern; codes A..F blank, dp always off.
module seg7_decode
    import seg_pkg::*;
#(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] bcd_i,
    output logic [7:0]       seg_o
);
    always_comb seg_o = ((bcd_i < 4'd10) ? SEG_PAT[bcd_i] : SEG_BLANK) ^ {8{ACT_LOW}};
endmodule

// File: rtl/key_count_display.sv
// key_count_display: decimal key-press counter driving a multiplexed 7-segment display.
// Define KEY_COUNT_LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module key_count_display
    import seg_pkg::*;
#(
    parameter int DIG_N       = DIG_N_DEF,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   anjian_en,
    input  logic                   wei_clk,
    output logic [DIG_N-1:0]       wei,
    output logic [7:0]             duan,
    output logic [BCD_W*DIG_N-1:0] cnt_bcd,
    output logic                   carry_out
);
    logic [1:0]             sync_q;
    logic                   edge_q;
    logic [BCD_W*DIG_N-1:0] cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic [2:0]             idx_q, idx_d;
    logic                   active_q, active_d;
    logic [DIG_N-1:0]       wei_q, wei_d;
    logic [7:0]             duan_q, duan_d;
    logic                   tick, c, nine, lz;
    logic [BCD_W-1:0]       dig, code;
    logic [7:0]             seg;
    always_comb begin
        tick = sync_q[1] & ~edge_q;
        idx_d = tick ? ((idx_q >= 3'(DIG_N - 1)) ? 3'd0 : idx_q + 3'd1) : idx_q;
        active_d = active_q | tick;
        cnt_d = cnt_q;
        c = anjian_en;
        nine = 1'b0;
        for (int i = 0; i < DIG_N; i++) begin
            nine = cnt_q[BCD_W*i +: BCD_W] == 4'd9;
            cnt_d[BCD_W*i +: BCD_W] = c ? (nine ? 4'd0 : cnt_q[BCD_W*i +: BCD_W] + 4'd1)
                                        : cnt_q[BCD_W*i +: BCD_W];
            c = c & nine;
        end
        carry_d = c;
        // The digit shown next cycle is the one the new index points at, pre-increment.
        dig = cnt_q[BCD_W*idx_d +: BCD_W];
        lz = idx_d != 3'd0;
        for (int i = 0; i < DIG_N; i++)
            lz = lz & ((i < int'(idx_d)) | (cnt_q[BCD_W*i +: BCD_W] == 4'd0));
`ifdef KEY_COUNT_LEAD_ZERO_BLANK_EN
        code = lz ? 4'hF : dig;
`else
        code = dig;
`endif
        wei_d = active_d ? (DIG_N'(1) << idx_d) ^ {DIG_N{SEG_ACT_LOW}} : {DIG_N{SEG_ACT_LOW}};
    end
    seg7_decode #(.ACT_LOW(SEG_ACT_LOW)) u_dec (.bcd_i(code), .seg_o(seg));
    assign duan_d = active_d ? seg : {8{SEG_ACT_LOW}};
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= '0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            active_q <= 1'b0;
            wei_q    <= {DIG_N{SEG_ACT_LOW}};
            duan_q   <= {8{SEG_ACT_LOW}};
        end else begin
            sync_q   <= {sync_q[0], wei_clk};
            edge_q   <= sync_q[1];
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            wei_q    <= wei_d;
            duan_q   <= duan_d;
        end
    end
    assign wei       = wei_q;
    assign duan      = duan_q;
    assign cnt_bcd   = cnt_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_key_count_display.sv
// tb_key_count_display: random and directed stimulus against an integer-count reference model.
module tb_key_count_display;
    localparam int DN = 4;
    localparam int MOD = 10000;
    logic clk = 1'b0, rst = 1'b0, anjian_en = 1'b0, wei_clk = 1'b0;
    logic [DN-1:0] wei;
    logic [7:0] duan;
    logic [4*DN-1:0] cnt_bcd;
    logic carry_out;
    int n_chk = 0, n_pass = 0;
    int half = 0, ph = 0;
    logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int m_cnt = 0, m_idx = 0, m_d = 0;
    bit m_carry = 0, m_act = 0, m_tick = 0, m_blank = 0, p1 = 0, p2 = 0, p3 = 0;
    logic [DN-1:0] m_wei = '1;
    logic [7:0] m_duan = 8'hFF;
    bit ok;

    key_count_display #(.DIG_N(DN), .SEG_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .anjian_en(anjian_en), .wei_clk(wei_clk),
        .wei(wei), .duan(duan), .cnt_bcd(cnt_bcd), .carry_out(carry_out));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [4*DN-1:0] to_bcd(input int v);
        logic [4*DN-1:0] r = '0;
        for (int i = 0; i < DN; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: count as a plain integer, tick = wei_clk rise seen two edges late.
    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_carry = 0; m_idx = 0; m_act = 0;
            p1 = 0; p2 = 0; p3 = 0;
            m_wei = '1; m_duan = 8'hFF;
        end else begin
            m_tick = p2 && !p3;
            p3 = p2; p2 = p1; p1 = wei_clk;
            if (m_tick) begin
                m_idx = (m_idx + 1) % DN;
                m_act = 1;
            end
            m_d = (m_cnt / (10 ** m_idx)) % 10;
            m_blank = 0;
`ifdef KEY_COUNT_LEAD_ZERO_BLANK_EN
            m_blank = (m_idx != 0) && (m_cnt < 10 ** m_idx);
`endif
            m_wei = m_act ? ~(DN'(1) << m_idx) : '1;
            m_duan = m_act ? ~(m_blank ? 8'h00 : pat[m_d]) : 8'hFF;
            m_carry = anjian_en && (m_cnt == MOD - 1);
            m_cnt = (m_cnt + int'(anjian_en)) % MOD;
        end
        #1;
        chk("m_cnt", 32'(cnt_bcd), 32'(to_bcd(m_cnt)));
        chk("m_carry", 32'(carry_out), 32'(m_carry));
        chk("m_wei", 32'(wei), 32'(m_wei));
        chk("m_duan", 32'(duan), 32'(m_duan));
    end

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (half > 0) begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    wei_clk = ~wei_clk;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; anjian_en = 1'b0; wei_clk = 1'b0; ph = 0;
        run(3);
        rst = 1'b1;
    endtask

    task automatic wait_wei(input logic [DN-1:0] w, output bit found);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (wei === w) found = 1;
            else run(1);
        end
    endtask

    initial begin
        half = 0;
        do_reset();
        run(4);
        chk("rst_cnt", 32'(cnt_bcd), 32'h0);
        chk("rst_wei", 32'(wei), 32'hF);
        chk("rst_duan", 32'(duan), 32'hFF);
        chk("rst_carry", 32'(carry_out), 32'h0);
        half = 20;
        run(400);
        for (int i = 0; i < 12; i++) begin
            anjian_en = 1'b1; run(1);
            anjian_en = 1'b0; run(1);
        end
        chk("cnt12", 32'(cnt_bcd), 32'h0012);
        wait_wei(4'b1101, ok);
        chk("wait_d1", 32'(ok), 32'h1);
        chk("duan_d1", 32'(duan), 32'hF9);
        wait_wei(4'b1110, ok);
        chk("wait_d0", 32'(ok), 32'h1);
        chk("duan_d0", 32'(duan), 32'hA4);
        half = 0;
        do_reset();
        anjian_en = 1'b1;
        run(MOD - 1);
        anjian_en = 1'b0;
        chk("cnt9999", 32'(cnt_bcd), 32'h9999);
        chk("carry_pre", 32'(carry_out), 32'h0);
        anjian_en = 1'b1; run(1); anjian_en = 1'b0;
        chk("wrap_cnt", 32'(cnt_bcd), 32'h0);
        chk("wrap_carry", 32'(carry_out), 32'h1);
        run(1);
        chk("carry_1clk", 32'(carry_out), 32'h0);
        do_reset();
        anjian_en = 1'b1; run(7); anjian_en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wei_clk = 1'b1; run(5);
            wei_clk = 1'b0; run(5);
        end
        wei_clk = 1'b1; run(2);
        anjian_en = 1'b1; run(1); anjian_en = 1'b0;
        chk("coll_wei", 32'(wei), 32'hE);
        chk("coll_pre", 32'(duan), 32'hF8);
        run(1);
        chk("coll_post", 32'(duan), 32'h80);
        chk("coll_cnt", 32'(cnt_bcd), 32'h0008);
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) half = $urandom_range(3, 25);
            anjian_en = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) != 0);
            run(1);
        end
        rst = 1'b1; anjian_en = 1'b1; half = 7;
        run(60);
        anjian_en = 1'b0;
        rst = 1'b0; run(1); rst = 1'b1;
        chk("mid_rst_cnt", 32'(cnt_bcd), 32'h0);
        chk("mid_rst_wei", 32'(wei), 32'hF);
        chk("mid_rst_duan", 32'(duan), 32'hFF);
        chk("mid_rst_carry", 32'(carry_out), 32'h0);
        run(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
